i2f_pipe: RTL and testbench
===========================

I2F_PIPE -- requirements
Module: i2f_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 16, integer input width, legal range 2..64.
REQ-002 SHALL have parameter SIGNED, default 0; 0 means i_number is unsigned, 1 means two's complement.
REQ-003 SHALL have parameter ROUND, default 1; 0 means truncate, 1 means round-to-nearest-even.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, i_number holds a valid sample.
REQ-007 SHALL have port in_ready, output, 1, the block accepts a sample this cycle.
REQ-008 SHALL have port i_number, input, IN_W, integer operand.
REQ-009 SHALL have port out_valid, output, 1, f_number and inexact are valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-011 SHALL have port f_number, output, 32, IEEE-754 single: sign, exponent[7:0], mantissa[22:0].
REQ-012 SHALL have port inexact, output, 1, nonzero bits were discarded by truncation or rounding.

Function
REQ-013 SHALL be a 3-stage pipeline, so an accepted sample appears on out_valid exactly 3 cycles later when there is no stall.
- S1: capture and take the absolute value.
- S2: leading-one detect and left-normalise.
- S3: round and pack.
REQ-014 SHALL complete a transfer on either side only when valid and ready are both 1 in the same cycle.
REQ-015 SHALL drive in_ready = out_ready OR NOT out_valid, and SHALL stall all stages together while out_valid=1 and out_ready=0.
REQ-016 SHALL, during a stall, hold f_number, inexact and out_valid stable and SHALL NOT lose or duplicate samples.
REQ-017 SHALL, with SIGNED=1, set sign to i_number[IN_W-1] and convert magnitude = |i_number| computed in IN_W bits unsigned.
- -2^(IN_W-1) SHALL yield magnitude 2^(IN_W-1), not overflow.
REQ-018 SHALL, with SIGNED=0, force sign=0.
REQ-019 SHALL compute exponent = 127 + p, where p is the index of the most significant 1 of the magnitude.
REQ-020 SHALL set the mantissa to the 23 bits below the leading one, left-aligned and zero-filled when p<23.
REQ-021 SHALL, when p>23, take guard bit = bit p-24 and sticky = OR of all bits below it; inexact = guard OR sticky.
REQ-022 SHALL, with ROUND=1, increment the mantissa when guard AND (sticky OR mantissa LSB).
- A mantissa carry-out SHALL clear the mantissa and add 1 to the exponent.
REQ-023 SHALL, with ROUND=0, discard the low bits and still report inexact.
REQ-024 SHALL produce f_number=32'h0000_0000 with inexact=0 for a zero magnitude, including under SIGNED=1.
REQ-025 SHALL accept back-to-back samples every cycle while out_ready=1 (throughput 1/cycle).
REQ-026 SHALL be fully synchronous to clk apart from rst_n, with no combinational path from i_number to f_number.

Reset
REQ-027 SHALL, while rst_n=0, force all stage valid flags, out_valid, f_number and inexact to 0.
REQ-028 SHALL discard in-flight samples on reset mid-operation and emit nothing for them after rst_n rises.
REQ-029 SHALL present in_ready=1 in the first cycle after reset release.

Structure
REQ-030 SHALL take the following constants from the shared package float_pkg, shared with future float blocks:
- F_BIAS=127, F_EXP_W=8, F_MAN_W=23.
- A typedef for the packed {sign, exponent, mantissa} float word.
REQ-031 SHALL instantiate one sub-module, lead_one_enc, a priority encoder parametrised on width.
- Returns the index of the highest set bit plus a zero flag.
- Successor of the fixed 16-bit encoder.
REQ-032 SHALL keep stage registers in i2f_pipe itself, with no further sub-modules.

Verification
REQ-033 IN_W=16, SIGNED=0: inputs 1, 0, 0xFFFF -> f_number 0x3F800000, 0x00000000, 0x477FFF00, all with inexact=0, each 3 cycles after acceptance.
REQ-034 IN_W=16, SIGNED=1: inputs 0x8000, 0xFFFF -> 0xC7000000, 0xBF800000.
REQ-035 IN_W=32, ROUND=1:
- 16777217 -> 0x4B800000, inexact=1 (tie to even).
- 33554431 -> 0x4C000000, inexact=1 (carry into exponent).
- With ROUND=0, 33554431 -> 0x4BFFFFFF, inexact=1.
REQ-036 Backpressure: stream 8 samples back-to-back while holding out_ready=0 for 5 cycles mid-stream -> all 8 results emitted in order, none duplicated, outputs stable during the stall.
REQ-037 Reset mid-operation: pulse rst_n low with 3 samples in flight -> out_valid=0 and f_number=0 immediately, and no stale output after release.

Source files
------------

// File: rtl/float_pkg.sv
// Shared IEEE-754 single-precision constants and word layout for the float
// datapath blocks.
package float_pkg;

   localparam int F_BIAS  = 127;
   localparam int F_EXP_W = 8;
   localparam int F_MAN_W = 23;

   typedef struct packed {
      logic               sign;
      logic [F_EXP_W-1:0] expo;
      logic [F_MAN_W-1:0] man;
   } float_t;

   function automatic float_t float_pack(input logic               s,
                                         input logic [F_EXP_W-1:0] e,
                                         input logic [F_MAN_W-1:0] m);
      float_t f;
      f.sign = s;
      f.expo = e;
      f.man  = m;
      return f;
   endfunction

endpackage

// File: rtl/lead_one_enc.sv
// Width-parametrised priority encoder: index of the highest set bit, plus a
// flag for an all-zero input.
module lead_one_enc #(
   parameter int W = 16,
   localparam int IDX_W = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]     din,
   output logic [IDX_W-1:0] idx,
   output logic             zero
);

   always_comb begin
      idx = '0;
      for (int i = 0; i < W; i++) begin
         if (din[i]) idx = IDX_W'(i);
      end
   end

   assign zero = ~|din;

endmodule

// File: rtl/i2f_pipe.sv
// Integer to IEEE-754 single converter: 3-stage pipeline (abs, normalise,
// round/pack) with a valid/ready handshake and whole-pipe stall.
module i2f_pipe
   import float_pkg::*;
#(
   parameter int IN_W   = 16,
   parameter int SIGNED = 0,
   parameter int ROUND  = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IN_W-1:0] i_number,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     f_number,
   output logic            inexact
);

   localparam int IDX_W = $clog2(IN_W);

   function automatic logic [IN_W-1:0] abs_mag(input logic [IN_W-1:0] x,
                                               input logic            neg);
      return neg ? (~x + 1'b1) : x;
   endfunction

   // norm has its leading one at bit IN_W-1; returns {inexact, float word}.
   function automatic logic [32:0] round_pack(input logic               sgn,
                                              input logic               zero,
                                              input logic [F_EXP_W-1:0] e,
                                              input logic [IN_W-1:0]    norm);
      logic [IN_W+23:0]    ext;
      logic [F_MAN_W-1:0]  man;
      logic                guard, sticky, inc;
      logic [F_MAN_W:0]    sum;
      logic [F_EXP_W-1:0]  e_out;
      float_t              fw;
      ext    = {norm, 24'd0};
      man    = ext[IN_W+22:IN_W];
      guard  = ext[IN_W-1];
      sticky = |ext[IN_W-2:0];
      inc    = (ROUND != 0) && guard && (sticky || man[0]);
      sum    = {1'b0, man} + {{F_MAN_W{1'b0}}, inc};
      e_out  = e + {{(F_EXP_W-1){1'b0}}, sum[F_MAN_W]};
      fw     = float_pack(sgn, e_out, sum[F_MAN_W-1:0]);
      if (zero) return 33'd0;
      return {guard | sticky, fw};
   endfunction

   logic                advance;
   logic                neg_in;
   logic                vld_p0, vld_p1, vld_p2;
   logic                sign_p0, sign_p1;
   logic [IN_W-1:0]     mag_p0, norm_p1;
   logic                zero_p1;
   logic [F_EXP_W-1:0]  expo_p1;
   logic [31:0]         f_p2;
   logic                inexact_p2;
   logic [IDX_W-1:0]    lead_idx;
   logic                lead_zero;
   logic [IDX_W-1:0]    shamt;
   logic [32:0]         packed_res;

   assign in_ready  = out_ready | ~vld_p2;
   assign advance   = in_ready;
   assign neg_in    = (SIGNED != 0) && i_number[IN_W-1];

   lead_one_enc #(.W(IN_W)) u_lod (
      .din  (mag_p0),
      .idx  (lead_idx),
      .zero (lead_zero)
   );

   assign shamt      = IDX_W'(IN_W - 1) - lead_idx;
   assign packed_res = round_pack(sign_p1, zero_p1, expo_p1, norm_p1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else if (advance) begin
         vld_p0 <= in_valid;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
      end
   end

   // S1: capture and absolute value / S2: leading-one detect and normalise
   always_ff @(posedge clk) begin
      if (advance) begin
         sign_p0 <= neg_in;
         mag_p0  <= abs_mag(i_number, neg_in);
         sign_p1 <= sign_p0;
         zero_p1 <= lead_zero;
         expo_p1 <= 8'(F_BIAS) + 8'(lead_idx);
         norm_p1 <= mag_p0 << shamt;
      end
   end

   // S3: round and pack into the output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_p2       <= '0;
         inexact_p2 <= 1'b0;
      end else if (advance) begin
         f_p2       <= packed_res[31:0];
         inexact_p2 <= packed_res[32];
      end
   end

   assign out_valid = vld_p2;
   assign f_number  = f_p2;
   assign inexact   = inexact_p2;

endmodule

// File: tb/tb_i2f_pipe.sv
// Bench for i2f_pipe: four configurations share one handshake; a scoreboard
// holds expected results for all four lanes per accepted sample.
module tb_i2f_pipe;

   typedef struct packed {
      logic [3:0][32:0] e;
      int               cyc;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] din;
   logic        ir [4];
   logic        ov [4];
   logic [31:0] fo [4];
   logic        ix [4];

   int   nchk = 0;
   int   nerr = 0;
   int   cyc  = 0;
   bit   nostall = 1'b0;
   ent_t sb[$];

   logic        stall_prev = 1'b0;
   logic [31:0] fo_prev [4];
   logic        ix_prev [4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   i2f_pipe #(.IN_W(16), .SIGNED(0), .ROUND(1)) u_l0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
      .i_number(din[15:0]), .out_valid(ov[0]), .out_ready(out_ready),
      .f_number(fo[0]), .inexact(ix[0]));
   i2f_pipe #(.IN_W(16), .SIGNED(1), .ROUND(1)) u_l1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
      .i_number(din[15:0]), .out_valid(ov[1]), .out_ready(out_ready),
      .f_number(fo[1]), .inexact(ix[1]));
   i2f_pipe #(.IN_W(32), .SIGNED(0), .ROUND(1)) u_l2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
      .i_number(din), .out_valid(ov[2]), .out_ready(out_ready),
      .f_number(fo[2]), .inexact(ix[2]));
   i2f_pipe #(.IN_W(32), .SIGNED(0), .ROUND(0)) u_l3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
      .i_number(din), .out_valid(ov[3]), .out_ready(out_ready),
      .f_number(fo[3]), .inexact(ix[3]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      nchk++;
      assert (obs === exp_v) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Reference conversion by integer division into quotient and remainder.
   function automatic logic [32:0] model(input logic [31:0] x, input int w,
                                         input bit sg, input bit rnd);
      longint unsigned xv, mag, q, rem, half;
      int p, sh;
      logic s, inx;
      logic [22:0] man;
      xv  = {32'd0, x} & ((64'd1 << w) - 64'd1);
      s   = sg && xv[w-1];
      mag = s ? ((64'd1 << w) - xv) : xv;
      if (mag == 0) return 33'd0;
      p = 0;
      for (int i = 0; i < 64; i++) if (mag[i]) p = i;
      inx = 1'b0;
      if (p <= 23) begin
         man = 23'(mag << (23 - p));
      end else begin
         sh   = p - 23;
         q    = mag >> sh;
         rem  = mag - (q << sh);
         half = 64'd1 << (sh - 1);
         inx  = (rem != 0);
         if (rnd && (rem > half || (rem == half && q[0]))) q++;
         if (q == (64'd1 << 24)) begin
            q = q >> 1;
            p++;
         end
         man = 23'(q);
      end
      return {inx, s, 8'(127 + p), man};
   endfunction

   function automatic logic [3:0][32:0] all_model(input logic [31:0] d);
      logic [3:0][32:0] e;
      e[0] = model(d, 16, 1'b0, 1'b1);
      e[1] = model(d, 16, 1'b1, 1'b1);
      e[2] = model(d, 32, 1'b0, 1'b1);
      e[3] = model(d, 32, 1'b0, 1'b0);
      return e;
   endfunction

   task automatic send_core(input logic [31:0] d, input logic [3:0][32:0] e);
      int   b;
      ent_t ent;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      din      = d;
      #1;
      b = 0;
      while (!ir[0] && b < 100) begin
         @(posedge clk);
         #2;
         b++;
      end
      if (b >= 100) chk("in_ready_timeout", 64'(ir[0]), 64'd1);
      ent.e   = e;
      ent.cyc = cyc;
      sb.push_back(ent);
   endtask

   task automatic send(input logic [31:0] d);
      send_core(d, all_model(d));
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int b;
      b = 0;
      while (sb.size() != 0 && b < 200) begin
         @(posedge clk);
         b++;
      end
      chk("drain", 64'(sb.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev <= 1'b0;
      end else begin
         if (stall_prev) begin
            for (int k = 0; k < 4; k++) begin
               chk($sformatf("stall_valid_l%0d", k), 64'(ov[k]), 64'd1);
               chk($sformatf("stall_f_l%0d", k), 64'(fo[k]), 64'(fo_prev[k]));
               chk($sformatf("stall_inexact_l%0d", k), 64'(ix[k]), 64'(ix_prev[k]));
            end
         end
         if (ov[0] && out_ready) begin
            if (sb.size() == 0) begin
               chk("spurious_output", 64'(ov[0]), 64'd0);
            end else begin
               ent_t ent;
               ent = sb.pop_front();
               for (int k = 0; k < 4; k++) begin
                  chk($sformatf("valid_l%0d", k), 64'(ov[k]), 64'd1);
                  chk($sformatf("f_number_l%0d", k), 64'(fo[k]), 64'(ent.e[k][31:0]));
                  chk($sformatf("inexact_l%0d", k), 64'(ix[k]), 64'(ent.e[k][32]));
               end
               if (nostall) chk("latency", 64'(cyc - ent.cyc), 64'd3);
            end
         end
         stall_prev <= ov[0] && !out_ready;
         for (int k = 0; k < 4; k++) begin
            fo_prev[k] <= fo[k];
            ix_prev[k] <= ix[k];
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0][32:0] e;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      din       = '0;
      #3;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("reset_valid_l%0d", k), 64'(ov[k]), 64'd0);
         chk($sformatf("reset_f_l%0d", k), 64'(fo[k]), 64'd0);
         chk($sformatf("reset_inexact_l%0d", k), 64'(ix[k]), 64'd0);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("ready_after_reset", 64'(ir[0]), 64'd1);

      // directed vectors, no stall, latency checked
      nostall = 1'b1;
      e = all_model(32'd1);      e[0] = {1'b0, 32'h3F80_0000};
      send_core(32'd1, e);
      e = all_model(32'd0);      e[0] = 33'd0; e[1] = 33'd0;
      send_core(32'd0, e);
      e = all_model(32'hFFFF);   e[0] = {1'b0, 32'h477F_FF00}; e[1] = {1'b0, 32'hBF80_0000};
      send_core(32'hFFFF, e);
      e = all_model(32'h8000);   e[1] = {1'b0, 32'hC700_0000};
      send_core(32'h8000, e);
      e = all_model(32'd16777217); e[2] = {1'b1, 32'h4B80_0000}; e[3] = {1'b1, 32'h4B80_0000};
      send_core(32'd16777217, e);
      e = all_model(32'd33554431); e[2] = {1'b1, 32'h4C00_0000}; e[3] = {1'b1, 32'h4BFF_FFFF};
      send_core(32'd33554431, e);
      e = all_model(32'h8000_0000); e[2] = {1'b0, 32'h4F00_0000}; e[3] = {1'b0, 32'h4F00_0000};
      send_core(32'h8000_0000, e);
      idle();
      drain();
      nostall = 1'b0;

      // 8 back-to-back samples with a 5-cycle stall mid-stream
      fork
         begin
            for (int i = 0; i < 8; i++) send($urandom() >> $urandom_range(0, 31));
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      idle();
      drain();

      // random values with random backpressure
      fork
         begin
            for (int i = 0; i < 30; i++) send($urandom() >> $urandom_range(0, 31));
         end
         begin
            repeat (60) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      idle();
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();

      // reset with three samples in flight
      for (int i = 0; i < 3; i++) send(32'h1234 + 32'(i));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("midreset_valid_l%0d", k), 64'(ov[k]), 64'd0);
         chk($sformatf("midreset_f_l%0d", k), 64'(fo[k]), 64'd0);
      end
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("ready_after_midreset", 64'(ir[0]), 64'd1);
      repeat (8) @(posedge clk);
      #1;
      chk("no_stale_valid", 64'(ov[0]), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end

endmodule
